// File: rtl/spi_adc_pkg.sv
// Shared types and command encoding for the MCP3008-style ADC sequencer.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    PUBLISH
  } state_t;

  localparam logic [7:0] CMD_START_BYTE   = 8'h01;
  localparam logic       CMD_SINGLE_ENDED = 1'b1;
  localparam int         CMD_LENGTH_BITS  = 24;

  // Byte 0: start bit. Byte 1: single-ended flag + channel. Byte 2: clock-out filler.
  function automatic logic [CMD_LENGTH_BITS-1:0] build_cmd(input logic [2:0] ch);
    return {CMD_START_BYTE, CMD_SINGLE_ENDED, ch, 4'h0, 8'h00};
  endfunction

endpackage

// File: rtl/spi_adc_sequencer_timer.sv
// Free-running sweep period timer; one-cycle tick every SAMPLE_PERIOD cycles while enabled.
module sample_period_timer #(
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int              CW   = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0]   LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/spi_adc_sequencer.sv
// Sweeps enabled ADC channels through an SPI controller and publishes {channel, sample}.
module spi_adc_sequencer
  import spi_adc_pkg::*;
#(
  parameter int NUM_CHANNELS   = 8,
  parameter int SAMPLE_PERIOD  = 100000,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int RESULT_BITS    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_CHANNELS-1:0]    channel_mask,
  output logic                       cmd_valid,
  output logic [CMD_LENGTH_BITS-1:0] cmd_data,
  input  logic                       cmd_ready,
  input  logic                       resp_valid,
  input  logic [CMD_LENGTH_BITS-1:0] resp_data,
  output logic                       sample_valid,
  output logic [2:0]                 sample_channel,
  output logic [RESULT_BITS-1:0]     sample_data,
  output logic                       sweep_done,
  output logic                       timeout_err,
  output logic                       overrun_err,
  input  logic                       err_clear
);

  localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                       state, state_next;
  logic [2:0]                   ch, ch_next;
  logic [NUM_CHANNELS-1:0]      mask_snap, mask_next;
  logic [CMD_LENGTH_BITS-1:0]   cmd_data_next;
  logic [2:0]                   sample_channel_next;
  logic [RESULT_BITS-1:0]       sample_data_next;
  logic                         sweep_done_next;
  logic [TW-1:0]                wait_cnt, wait_next;
  logic                         tick, tick_pending, tick_pending_next;
  logic                         timeout_err_next, overrun_err_next;
  logic                         consume, timeout_set, overrun_set;
  logic [NUM_CHANNELS-1:0]      search;
  logic                         found;
  logic [2:0]                   found_ch;
  logic                         unused_resp_bits;

  assign unused_resp_bits = ^resp_data[CMD_LENGTH_BITS-1:RESULT_BITS];

  sample_period_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  // IDLE searches the live mask; PUBLISH searches the snapshot above the current channel.
  always_comb begin
    found    = 1'b0;
    found_ch = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      search[i] = (state == IDLE) ? channel_mask[i] : (mask_snap[i] && (i > int'(ch)));
    end
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (search[i]) begin
        found    = 1'b1;
        found_ch = 3'(i);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next          = state;
    ch_next             = ch;
    mask_next           = mask_snap;
    cmd_data_next       = cmd_data;
    sample_channel_next = sample_channel;
    sample_data_next    = sample_data;
    sweep_done_next     = 1'b0;
    wait_next           = wait_cnt;
    consume             = 1'b0;
    timeout_set         = 1'b0;
    cmd_valid           = 1'b0;
    sample_valid        = 1'b0;

    case (state)
      IDLE: begin
        if (tick_pending && enable) begin
          consume   = 1'b1;
          mask_next = channel_mask;
          if (found) begin
            ch_next       = found_ch;
            cmd_data_next = build_cmd(found_ch);
            state_next    = ISSUE;
          end
        end
      end

      ISSUE: begin
        // Valid follows ready combinationally so it can never show without ready.
        cmd_valid = cmd_ready;
        if (cmd_ready) begin
          wait_next  = '0;
          state_next = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        if (resp_valid) begin
          sample_data_next    = resp_data[RESULT_BITS-1:0];
          sample_channel_next = ch;
          state_next          = PUBLISH;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else begin
          wait_next = wait_cnt + TW'(1);
        end
      end

      PUBLISH: begin
        sample_valid = 1'b1;
        if (found && enable) begin
          ch_next       = found_ch;
          cmd_data_next = build_cmd(found_ch);
          state_next    = ISSUE;
        end else begin
          sweep_done_next = !found;
          state_next      = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // A tick landing on the consume cycle refills the latch rather than overrunning.
    overrun_set = tick && tick_pending && !consume;
    if (!enable) begin
      tick_pending_next = 1'b0;
    end else if (tick) begin
      tick_pending_next = 1'b1;
    end else if (consume) begin
      tick_pending_next = 1'b0;
    end else begin
      tick_pending_next = tick_pending;
    end

    timeout_err_next = timeout_set || (timeout_err && !err_clear);
    overrun_err_next = overrun_set || (overrun_err && !err_clear);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ch             <= '0;
      mask_snap      <= '0;
      cmd_data       <= '0;
      sample_channel <= '0;
      sample_data    <= '0;
      sweep_done     <= 1'b0;
      wait_cnt       <= '0;
      tick_pending   <= 1'b0;
      timeout_err    <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      state          <= state_next;
      ch             <= ch_next;
      mask_snap      <= mask_next;
      cmd_data       <= cmd_data_next;
      sample_channel <= sample_channel_next;
      sample_data    <= sample_data_next;
      sweep_done     <= sweep_done_next;
      wait_cnt       <= wait_next;
      tick_pending   <= tick_pending_next;
      timeout_err    <= timeout_err_next;
      overrun_err    <= overrun_err_next;
    end
  end

endmodule

// File: doc/spi_adc_sequencer.md
Name: spi_adc_sequencer

Overview:
- Upstream command source and downstream result consumer for spi_controller, instantiated with TRANSACTION_LENGTH_BITS = 24.
- Periodically sweeps the enabled channels of an MCP3008-style 10-bit SPI ADC.
- For each channel it issues one 24-bit read command, waits for the 24-bit response, and publishes {channel, 10-bit sample}.
- Includes a period timer, a one-deep pending-tick latch, and a response-timeout watchdog.

Parameters:
- NUM_CHANNELS, 8, number of ADC channels swept; range 1..8.
- SAMPLE_PERIOD, 100000, clk cycles between sweep start ticks; must be >= 2.
- TIMEOUT_CYCLES, 10000, maximum cycles in WAIT_RESP before the block aborts to IDLE.
- RESULT_BITS, 10, width of the ADC result field.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  sweeps allowed while high.
- channel_mask  in  NUM_CHANNELS  bit i=1 includes channel i in the sweep; sampled at sweep start.
- cmd_valid  out  1  one-cycle command pulse to the controller's axiiv.
- cmd_data  out  24  command word to the controller's axiid.
- cmd_ready  in  1  controller's axiready.
- resp_valid  in  1  controller's axiov (one-cycle pulse).
- resp_data  in  24  controller's axiod.
- sample_valid  out  1  one-cycle pulse; a new sample is on sample_channel/sample_data.
- sample_channel  out  3  channel index of the published sample.
- sample_data  out  RESULT_BITS  ADC result.
- sweep_done  out  1  one-cycle pulse after the last enabled channel is published.
- timeout_err  out  1  sticky flag; a response timeout occurred.
- overrun_err  out  1  sticky flag; a tick arrived while a tick was already pending.
- err_clear  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; period counter 0; tick_pending 0; channel index 0; mask snapshot 0.
- Period timer:
  - Counts 0..SAMPLE_PERIOD-1 while enable=1; tick is asserted at count SAMPLE_PERIOD-1.
  - enable=0 holds the counter at 0 and clears tick_pending.
- tick_pending:
  - Set on tick; cleared when IDLE consumes it.
  - A tick while tick_pending=1 sets overrun_err; no second pending tick is stored.
- Command word: cmd_data = {8'h01, 1'b1, ch[2:0], 4'h0, 8'h00}.
  - Byte 0 carries the start bit, byte 1 selects single-ended mode and the channel.
- Response: sample_data = resp_data[RESULT_BITS-1:0]; upper response bits are ignored.
- States:
  - IDLE: if tick_pending && enable, snapshot channel_mask and clear tick_pending.
    - Mask snapshot = 0 -> stay in IDLE; no sweep_done.
    - Otherwise set ch = lowest set bit and go to ISSUE.
  - ISSUE: wait for cmd_ready=1, then drive cmd_valid=1 for exactly one cycle with cmd_data and go to WAIT_RESP. cmd_data is held stable until the next ISSUE.
  - WAIT_RESP:
    - On resp_valid, register the sample and go to PUBLISH.
    - If TIMEOUT_CYCLES elapse first, set timeout_err and go to IDLE; the sweep is abandoned and sweep_done is not pulsed.
  - PUBLISH: sample_valid=1 for one cycle.
    - If a higher set bit remains in the snapshot and enable=1, set ch = next set bit and go to ISSUE.
    - Otherwise pulse sweep_done (only if the sweep finished all channels) and go to IDLE.
- Latency: sample_valid is asserted exactly 1 cycle after the resp_valid cycle.
- Simultaneous events:
  - err_clear and a new error in the same cycle -> the flag ends set.
  - A tick in the same cycle IDLE consumes a pending tick -> tick_pending stays set; no overrun.
- enable falls mid-sweep: the in-flight transaction completes and is published, then the block returns to IDLE with no sweep_done.
- resp_valid outside WAIT_RESP is ignored.
- cmd_valid is never asserted while cmd_ready=0.
- Channel order is strictly ascending; disabled channels cost zero cycles.

Decomposition:
- Package spi_adc_pkg:
  - state enum {IDLE, ISSUE, WAIT_RESP, PUBLISH}.
  - Constants CMD_START_BYTE=8'h01, CMD_SINGLE_ENDED=1'b1, CMD_LENGTH_BITS=24.
  - Function build_cmd(ch).
- Sub-module sample_period_timer (clk, rst, enable, tick), parameter SAMPLE_PERIOD.
- Next-set-bit search stays inline as a combinational priority encoder.

Test Plan:
- Full mask, SAMPLE_PERIOD=200, bench model of the controller echoing resp_data = 0x000000 | (ch*100) -> eight samples, channels 0..7 in order with data 0,100,...,700; one sweep_done after channel 7.
- channel_mask=8'b1010_0100 -> cmd_data 24'h01A000, then 24'h01D000, then 24'h01F000; three samples; sweep_done once.
- cmd_ready held 0 for 50 cycles in ISSUE -> cmd_valid stays 0; it pulses exactly once, on the first cycle after cmd_ready rises.
- Model never responds, TIMEOUT_CYCLES=64 -> timeout_err=1 at WAIT_RESP entry+64, block returns to IDLE; next tick restarts at the lowest channel; err_clear -> timeout_err=0.
- Model stalls 3 periods; then check that tick_pending and overrun_err are set.
- rst asserted in WAIT_RESP (asynchronously, mid-cycle) -> all outputs 0 immediately; after release no command until the next tick; a late resp_valid is ignored.
